bp_cfg_sequencer: RTL and testbench
===================================

Name: bp_cfg_sequencer

Overview:
Post-reset configuration sequencer for a BlackParrot tile array. It walks every core tile in turn over a shared valid/ready config bus, one write per handshake, in this order: freeze, core ID, optional CCE microcode, CCE mode, unfreeze. It sits between the testbench/host boot logic and the per-tile config links, and serialises all configuration traffic onto one link.

Parameters:
num_core_p, 1, number of core tiles (cc_x_dim*cc_y_dim); range 1..64
cfg_addr_width_p, 16, config bus address width
cfg_data_width_p, 32, config bus data width
cce_ucode_els_p, 256, CCE microcode words per core (2**cce_pc_width)
cce_mode_p, 1, value written to the CCE-mode register (0 uncached, 1 normal)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; begins a sequence when idle or done
busy_o  out  1  sequence in progress
done_o  out  1  level; set when the sequence completes, cleared by the next accepted start_i
cfg_v_o  out  1  config write valid
cfg_ready_i  in  1  config link accepts the write
cfg_core_o  out  clog2(num_core_p) (min 1)  target core index
cfg_addr_o  out  cfg_addr_width_p  register address
cfg_data_o  out  cfg_data_width_p  write data
ucode_r_v_o  out  1  microcode ROM read strobe
ucode_addr_o  out  clog2(cce_ucode_els_p)  microcode ROM address
ucode_data_i  in  cfg_data_width_p  ROM data, valid the cycle after ucode_r_v_o

Behaviour:
- Reset (asynchronous assert, synchronous deassert to clk_i): state IDLE. All outputs are 0; counters are 0. Asserting reset mid-sequence aborts immediately. Nothing resumes after reset; the sequence restarts only on a new start_i.
- Register map (fixed):
  - FREEZE 0x0001: data 1 = freeze, 0 = unfreeze
  - CORE_ID 0x0002: data is the core index, zero-extended
  - CCE_MODE 0x0004: data is cce_mode_p
  - UCODE 0x8000+i: data is word i
- States: IDLE, FREEZE, CORE_ID, UC_RD, UC_WR, CCE_MODE, UNFREEZE, DONE.
- IDLE or DONE + start_i: go to FREEZE with core=0; clear done_o; set busy_o. start_i is ignored in all other states.
- Every write state drives cfg_v_o=1 with stable core/addr/data until cfg_ready_i. It advances on the edge where cfg_v_o && cfg_ready_i. Back-to-back writes take 1 cycle each.
- Core order: FREEZE -> CORE_ID -> [UC_RD -> UC_WR] x cce_ucode_els_p -> CCE_MODE -> UNFREEZE.
- UC_RD: one cycle, cfg_v_o=0, ucode_r_v_o=1, ucode_addr_o=i. The next cycle UC_WR captures ucode_data_i into a holding register, so data stays stable across stalls. After word cce_ucode_els_p-1 is accepted, i wraps to 0 and the state goes to CCE_MODE.
- UNFREEZE accepted:
  - core < num_core_p-1: increment core, go to FREEZE.
  - last core: go to DONE; busy_o=0 and done_o=1 from the next cycle.
- With cfg_ready_i held high, per-core cycles = 4 (+2*cce_ucode_els_p with the feature). There are no idle cycles between cores.
- The core counter never exceeds num_core_p-1. With num_core_p=1, cfg_core_o is a constant 0.

Optional Feature:
BP_CFG_SEQ_UCODE_LOAD_EN
- Defined: the UC_RD/UC_WR loop is present, as described above.
- Undefined: the UC states are removed; CORE_ID goes directly to CCE_MODE; ucode_r_v_o and ucode_addr_o are tied to 0; ucode_data_i is unused.

Test Plan:
- num_core_p=2, feature off, ready=1, start at cycle 0 -> 8 writes in cycles 1-8:
  - core0: (1,0x0001,1) (2,0x0002,0) (3,0x0004,1) (4,0x0001,0)
  - core1: same four writes with core=1
  - done_o=1 in cycle 9.
- Feature on, cce_ucode_els_p=4, ROM[i]=0xA0+i, num_core_p=1, ready=1 -> writes: freeze, id, 0x8000..0x8003 carrying 0xA0..0xA3, mode, unfreeze. done_o=1 at cycle 13.
- cfg_ready_i low for 3 cycles during UC_WR word 2 -> cfg_addr_o=0x8002 and cfg_data_o=0xA2 held for all 4 cycles; exactly one write is counted.
- start_i pulsed while busy -> ignored, no change to the sequence. start_i in DONE -> done_o drops next cycle; the sequence reruns identically.
- reset_n_i asserted mid-UCODE for core 1 -> outputs 0 asynchronously; after release the block stays IDLE with no writes until start_i.
- num_core_p=1, cfg_ready_i random at 50% -> write order matches the reference sequence, and the transfer count equals 4+cce_ucode_els_p.

Source files
------------

// File: rtl/bp_cfg_sequencer.sv
// bp_cfg_sequencer: serialises per-tile BlackParrot config writes onto one valid/ready link.
// Define BP_CFG_SEQ_UCODE_LOAD_EN to stream CCE microcode between CORE_ID and CCE_MODE.
module bp_cfg_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int cce_ucode_els_p  = 256,
  parameter int cce_mode_p       = 1,
  localparam int core_w_lp = num_core_p > 1 ? $clog2(num_core_p) : 1,
  localparam int uc_w_lp   = cce_ucode_els_p > 1 ? $clog2(cce_ucode_els_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_w_lp-1:0]        cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        ucode_r_v_o,
  output logic [uc_w_lp-1:0]          ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i
);
  typedef enum logic [2:0] {IDLE, FREEZE, CORE_ID, UC_RD, UC_WR, CCE_MODE, UNFREEZE, DONE} state_e;
  state_e                state_q;
  logic [core_w_lp-1:0]  core_q;
  logic                  last_core;
  logic [cfg_addr_width_p-1:0] uc_addr;
  logic [cfg_data_width_p-1:0] uc_data;
  assign last_core = core_q == core_w_lp'(num_core_p - 1);
`ifdef BP_CFG_SEQ_UCODE_LOAD_EN
  localparam state_e id_next_lp = UC_RD;
  logic [uc_w_lp-1:0]          idx_q;
  logic [cfg_data_width_p-1:0] hold_q;
  logic                        first_q;
  logic                        last_uc;
  assign last_uc = idx_q == uc_w_lp'(cce_ucode_els_p - 1);
  // ROM data is only valid in the first UC_WR cycle; later cycles replay the captured copy
  assign uc_data = first_q ? ucode_data_i : hold_q;
  assign uc_addr = cfg_addr_width_p'(16'h8000) | cfg_addr_width_p'(idx_q);
  assign ucode_r_v_o = state_q == UC_RD;
  assign ucode_addr_o = ucode_r_v_o ? idx_q : '0;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      idx_q   <= '0;
      hold_q  <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= state_q == UC_RD;
      if (state_q == UC_WR && first_q) hold_q <= ucode_data_i;
      if (state_q == UC_WR && cfg_ready_i) idx_q <= last_uc ? '0 : idx_q + 1'b1;
    end
`else
  localparam state_e id_next_lp = CCE_MODE;
  logic unused_ucode;
  assign unused_ucode = ^ucode_data_i;
  assign uc_data = '0;
  assign uc_addr = '0;
  assign ucode_r_v_o = 1'b0;
  assign ucode_addr_o = '0;
`endif
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      core_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_q <= FREEZE;
          core_q  <= '0;
        end
        FREEZE:   if (cfg_ready_i) state_q <= CORE_ID;
        CORE_ID:  if (cfg_ready_i) state_q <= id_next_lp;
`ifdef BP_CFG_SEQ_UCODE_LOAD_EN
        UC_RD:    state_q <= UC_WR;
        UC_WR:    if (cfg_ready_i) state_q <= last_uc ? CCE_MODE : UC_RD;
`endif
        CCE_MODE: if (cfg_ready_i) state_q <= UNFREEZE;
        UNFREEZE: if (cfg_ready_i) begin
          state_q <= last_core ? DONE : FREEZE;
          if (!last_core) core_q <= core_q + 1'b1;
        end
        default:  state_q <= IDLE;
      endcase
    end
  assign busy_o     = state_q != IDLE && state_q != DONE;
  assign done_o     = state_q == DONE;
  assign cfg_v_o    = state_q inside {FREEZE, CORE_ID, UC_WR, CCE_MODE, UNFREEZE};
  assign cfg_core_o = core_q;
  always_comb begin
    cfg_addr_o = state_q == FREEZE || state_q == UNFREEZE ? cfg_addr_width_p'(16'h0001)
               : state_q == CORE_ID                       ? cfg_addr_width_p'(16'h0002)
               : state_q == CCE_MODE                      ? cfg_addr_width_p'(16'h0004)
               : state_q == UC_WR                         ? uc_addr
               :                                            '0;
    cfg_data_o = state_q == FREEZE   ? cfg_data_width_p'(1)
               : state_q == CORE_ID  ? cfg_data_width_p'(core_q)
               : state_q == CCE_MODE ? cfg_data_width_p'(cce_mode_p)
               : state_q == UC_WR    ? uc_data
               :                       '0;
  end
endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// tb_bp_cfg_sequencer: directed checks of write order, timing, stalls, restart and reset abort.
module tb_bp_cfg_sequencer;
`ifdef BP_CFG_SEQ_UCODE_LOAD_EN
  localparam int E = 4;
  localparam logic [15:0] TA = 16'h8002;
  localparam logic [31:0] TD = 32'hA2;
`else
  localparam int E = 0;
  localparam logic [15:0] TA = 16'h0004;
  localparam logic [31:0] TD = 32'h1;
`endif
  localparam int NC  = 2;
  localparam int PER = 4 + E;
  localparam int CPC = 4 + 2 * E;

  logic        clk = 0, rst_n = 0, start = 0, ready = 1, start_b = 0;
  logic        busy, done, cfg_v, u_rv;
  logic [0:0]  cfg_core;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_data, rom_d = 32'hDEADBEEF;
  logic [1:0]  u_addr;
  logic        busy_b, done_b, cfg_v_b, u_rv_b;
  logic [0:0]  core_b;
  logic [15:0] addr_b;
  logic [31:0] data_b, rom_b = 32'hDEADBEEF;
  logic [1:0]  u_addr_b;

  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  int b_writes = 0, b_core_bad = 0, b_done_cyc = -1, b_t0 = 0;
  logic [63:0] log_w[$], exp_w[$];
  int log_c[$];

  bp_cfg_sequencer #(.num_core_p(NC), .cce_ucode_els_p(4), .cce_mode_p(1)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .cfg_v_o(cfg_v), .cfg_ready_i(ready), .cfg_core_o(cfg_core), .cfg_addr_o(cfg_addr),
    .cfg_data_o(cfg_data), .ucode_r_v_o(u_rv), .ucode_addr_o(u_addr), .ucode_data_i(rom_d));

  bp_cfg_sequencer #(.num_core_p(1), .cce_ucode_els_p(4), .cce_mode_p(1)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .cfg_v_o(cfg_v_b), .cfg_ready_i(1'b1), .cfg_core_o(core_b), .cfg_addr_o(addr_b),
    .cfg_data_o(data_b), .ucode_r_v_o(u_rv_b), .ucode_addr_o(u_addr_b), .ucode_data_i(rom_b));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_d <= u_rv ? 32'hA0 + 32'(u_addr) : 32'hDEADBEEF;
    rom_b <= u_rv_b ? 32'hA0 + 32'(u_addr_b) : 32'hDEADBEEF;
  end
  always @(negedge clk) begin
    if (cfg_v && ready) begin
      log_w.push_back({8'(cfg_core), cfg_addr, cfg_data});
      log_c.push_back(cyc);
    end
    if (cfg_v_b) b_writes++;
    if (core_b !== 1'b0) b_core_bad++;
    if (done_b && b_done_cyc < 0) b_done_cyc = cyc - b_t0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_w.delete();
    log_c.delete();
  endtask

  task automatic check_log(input string tag);
    exp_w.delete();
    for (int c = 0; c < NC; c++) begin
      exp_w.push_back({8'(c), 16'h0001, 32'h1});
      exp_w.push_back({8'(c), 16'h0002, 32'(c)});
      for (int i = 0; i < E; i++) exp_w.push_back({8'(c), 16'h8000 + 16'(i), 32'hA0 + 32'(i)});
      exp_w.push_back({8'(c), 16'h0004, 32'h1});
      exp_w.push_back({8'(c), 16'h0001, 32'h0});
    end
    chk({tag, "_count"}, 64'(log_w.size()), 64'(NC * PER));
    for (int i = 0; i < log_w.size() && i < exp_w.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), log_w[i], exp_w[i]);
  endtask

  task automatic kick();
    start = 1;
    t0 = cyc;
    step();
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int lim, output int dc);
    int n = 0;
    while (!done && n < lim) begin
      step();
      n++;
    end
    chk({tag, "_done_reached"}, 64'(done), 64'd1);
    dc = cyc - t0;
  endtask

  initial begin
    int dc, dc2, hold;
    repeat (3) step();
    chk("reset_outputs", {cfg_v, busy, done, u_rv, cfg_core, u_addr, cfg_addr, cfg_data}, 64'd0);
    rst_n = 1;
    step();
    chk("idle_no_writes", 64'(log_w.size()), 64'd0);

    ready = 1;
    start_b = 1;
    b_t0 = cyc;
    kick();
    start_b = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done("run1", 500, dc);
    chk("run1_done_cycle", 64'(dc), 64'(1 + NC * CPC));
    chk("run1_busy_low", 64'(busy), 64'd0);
    check_log("run1");
    if (log_c.size() > 0) chk("run1_last_write_cycle", 64'(log_c[log_c.size() - 1] - t0), 64'(NC * CPC));
    if (E == 0)
      for (int i = 0; i < log_c.size(); i++) chk($sformatf("run1_cyc%0d", i), 64'(log_c[i] - t0), 64'(i + 1));
    chk("b_done_cycle", 64'(b_done_cyc), 64'(1 + CPC));
    chk("b_write_count", 64'(b_writes), 64'(PER));
    chk("b_core_const0", 64'(b_core_bad), 64'd0);

    clear_log();
    kick();
    chk("done_drops_on_restart", 64'(done), 64'd0);
    repeat (3) step();
    start = 1;
    step();
    start = 0;
    wait_done("run2", 500, dc2);
    chk("run2_done_cycle", 64'(dc2), 64'(1 + NC * CPC));
    check_log("run2");

    clear_log();
    hold = 0;
    kick();
    for (int n = 0; n < 500 && !done; n++) begin
      if (cfg_v && cfg_addr == TA && cfg_core == 1'b0) begin
        hold++;
        chk($sformatf("stall_data%0d", hold), 64'(cfg_data), 64'(TD));
        ready = hold >= 4;
      end else ready = 1;
      step();
    end
    ready = 1;
    chk("stall_hold_cycles", 64'(hold), 64'd4);
    chk("stall_done", 64'(done), 64'd1);
    check_log("stall");

    clear_log();
    kick();
    for (int n = 0; n < 3000 && !done; n++) begin
      ready = 1'($urandom_range(0, 1));
      step();
    end
    ready = 1;
    chk("rand_done", 64'(done), 64'd1);
    check_log("rand");

    clear_log();
    kick();
    for (int n = 0; n < 500 && !(cfg_core == 1'b1 && cfg_addr == TA); n++) step();
    chk("abort_point_reached", {cfg_core, cfg_addr}, {1'b1, TA});
    #2 rst_n = 0;
    #1 chk("async_reset_outputs", {cfg_v, busy, done, u_rv, cfg_core, u_addr, cfg_addr, cfg_data}, 64'd0);
    step();
    step();
    rst_n = 1;
    clear_log();
    repeat (10) step();
    chk("post_reset_no_writes", 64'(log_w.size()), 64'd0);
    chk("post_reset_idle", {busy, done, cfg_v}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
